// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the two-requester adder arbiter.
package adder_arb_pkg;

  localparam int unsigned CntWidth = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StResp
  } state_e;

  typedef logic id_t;

  localparam id_t IdReq0 = 1'b0;
  localparam id_t IdReq1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the requester not granted last time wins.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = valid_i;
    if (valid_i == 2'b11) begin
      grant_o = last_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Arbitrates two requesters onto one external ripple-carry adder and waits SETTLE cycles
// before capturing its sum. Define ADDER_ARB_OVF_EN to add the signed-overflow output rsp_ovf.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  input  logic [WIDTH-1:0] add_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout
`ifdef ADDER_ARB_OVF_EN
  ,
  output logic             rsp_ovf
`endif
);

  localparam logic [CntWidth-1:0] CntLoad = CntWidth'(SETTLE - 1);

  state_e                state_q;
  logic [WIDTH-1:0]      a_q, b_q, rsp_sum_q;
  logic [CntWidth-1:0]   cnt_q;
  id_t                   id_q, last_q, rsp_id_q;
  logic                  rsp_cout_q;
  logic [1:0]            grant;
  logic                  idle_ok;
  logic                  unused_carry;

  // Only the top carry bits are meaningful; the rest of the vector is ignored.
  assign unused_carry = ^add_carry[WIDTH-2:0];

  rr_arb2 u_rr_arb2 (
    .valid_i ({req1_valid, req0_valid}),
    .last_i  (last_q),
    .grant_o (grant)
  );

  assign idle_ok    = (state_q == StIdle) && !rst;
  assign req0_ready = idle_ok && grant[0];
  assign req1_ready = idle_ok && grant[1];

  assign add_a     = a_q;
  assign add_b     = b_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;

`ifdef ADDER_ARB_OVF_EN
  logic rsp_ovf_q;
  assign rsp_ovf = rsp_ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= IdReq0;
      last_q     <= IdReq1;  // req0 wins the first tie
      cnt_q      <= '0;
      rsp_sum_q  <= '0;
      rsp_cout_q <= 1'b0;
      rsp_id_q   <= IdReq0;
`ifdef ADDER_ARB_OVF_EN
      rsp_ovf_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req0_ready || req1_ready) begin
            id_q    <= req1_ready;
            last_q  <= req1_ready;
            a_q     <= req1_ready ? req1_a : req0_a;
            b_q     <= req1_ready ? req1_b : req0_b;
            cnt_q   <= CntLoad;
            state_q <= StSettle;
          end
        end
        StSettle: begin
          if (cnt_q == '0) begin
            rsp_sum_q  <= add_sum;
            rsp_cout_q <= add_carry[WIDTH-1];
            rsp_id_q   <= id_q;
`ifdef ADDER_ARB_OVF_EN
            rsp_ovf_q  <= add_carry[WIDTH-1] ^ add_carry[WIDTH-2];
`endif
            state_q    <= StResp;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/sum width; legal range 2..32.
REQ-002 SHALL have parameter SETTLE, default 2, number of cycles allowed for external ripple-carry adder propagation; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports req0_valid, req1_valid  input  1  requester operand valid.
REQ-006 SHALL have ports req0_ready, req1_ready  output  1  requester accept strobe.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH  requester operands.
REQ-008 SHALL have ports add_a, add_b  output  WIDTH  operands driven to the shared adder.
REQ-009 SHALL have ports add_sum  input  WIDTH  adder sum; add_carry  input  WIDTH  adder per-bit carry vector.
REQ-010 SHALL have ports rsp_valid  output  1; rsp_ready  input  1; rsp_id  output  1 (0 = req0, 1 = req1); rsp_sum  output  WIDTH; rsp_cout  output  1.

Function
REQ-011 SHALL implement FSM states IDLE, SETTLE, RESP.
REQ-012 In IDLE, reqN_ready SHALL be combinationally high only for the single granted requester with reqN_valid high; both readies are low in SETTLE and RESP.
REQ-013 Grant SHALL be round-robin: if only one valid, grant it; if both valid, grant the requester not granted most recently; after reset, req0 has priority.
REQ-014 On accept (valid and ready in IDLE), the operands and the grant id SHALL be registered, last-grant pointer updated, settle counter loaded with SETTLE-1, and state moved to SETTLE.
REQ-015 add_a/add_b SHALL be driven only from the registered operands, never combinationally from request ports.
REQ-016 In SETTLE, the counter SHALL decrement each cycle; in the cycle it reads 0, add_sum, add_carry[WIDTH-1] and id SHALL be latched into rsp_sum, rsp_cout and rsp_id, and state moved to RESP.
REQ-017 rsp_valid SHALL be high exactly while in RESP; latency from accept edge to rsp_valid high is SETTLE+1 cycles.
REQ-018 rsp_sum, rsp_cout, rsp_id SHALL be stable while rsp_valid high and rsp_ready low.
REQ-019 In RESP with rsp_ready high, state SHALL return to IDLE on the next edge; a new accept is possible only from IDLE, giving one transaction per SETTLE+2 cycles minimum.
REQ-020 Requests arriving during SETTLE or RESP SHALL be held off (ready low) and not lost; requesters keep valid asserted.
REQ-021 Sum arithmetic SHALL be modulo 2^WIDTH; carry-out is bit WIDTH-1 of add_carry; carry-in to adder is always 0.

Reset
REQ-022 When rst is high at an edge, state SHALL be IDLE, rsp_valid 0, rsp_sum 0, rsp_cout 0, rsp_id 0, operand registers 0, counter 0, last-grant pointer set so req0 wins next tie.
REQ-023 Reset mid-transaction (SETTLE or RESP) SHALL abort it with no response produced; readies low during the reset cycle.

Configuration
REQ-024 With macro ADDER_ARB_OVF_EN defined, SHALL add output rsp_ovf (1 bit) = add_carry[WIDTH-1] XOR add_carry[WIDTH-2], latched with rsp_sum, reset 0, stable as rsp_sum.
REQ-025 Without ADDER_ARB_OVF_EN, rsp_ovf port and its register SHALL not exist; all other behaviour identical.

Structure
REQ-026 Shared package adder_arb_pkg SHALL hold the FSM state enum, the requester id type, and the SETTLE counter width constant (4).
REQ-027 Round-robin grant logic SHALL be a sub-module rr_arb2 (inputs: two valids, last-grant; outputs: one-hot grant); the adder itself is external.

Verification
REQ-028 Single req0: a=0x0000_0005, b=0x0000_0003, SETTLE=2 -> rsp_valid 3 cycles after accept, rsp_sum=0x8, rsp_id=0, rsp_cout=0.
REQ-029 Both valid from reset, req0 a=1 b=1, req1 a=2 b=2 -> req0 granted first (sum 2, id 0), then req1 (sum 4, id 1); next tie grants req0.
REQ-030 Wrap: a=0xFFFF_FFFF, b=0x0000_0001 -> rsp_sum=0, rsp_cout=1; with ADDER_ARB_OVF_EN, rsp_ovf=0; a=0x7FFF_FFFF, b=1 -> rsp_ovf=1, rsp_cout=0.
REQ-031 Backpressure: rsp_ready low 5 cycles -> rsp_* held constant, both readies low, no new accept until one cycle after rsp_ready high.
REQ-032 rst asserted in SETTLE -> no rsp_valid, outputs zero next cycle, pending req1 then granted in IDLE.
